load_scoreboard: RTL and testbench
==================================

// Module: load_scoreboard
// PURPOSE
// - Tracks destination registers of loads issued from ID that are still waiting on the multi-cycle cache.
// - Generates the load-use stall for the ID stage.
// - Issue side pushes a tag; writeback side pops it. ID sources are compared against all pending tags every cycle.
// - Replaces single-stage EX-only load detection now that a load may stay in MEM/cache for many cycles.
// PARAMETERS
// - DEPTH   4  max outstanding loads (power of 2, >=2)
// - CNT_W   3  width of pending_cnt; must satisfy 2**CNT_W > DEPTH
// PORTS
// - clk          in   1      core clock
// - reset        in   1      synchronous, active-high
// - issue_valid  in   1      a load leaves ID into EX this cycle
// - issue_rd     in   5      its destination register
// - resp_valid   in   1      oldest pending load writes back this cycle (responses return in order)
// - id_rs1       in   5      ID source register 1
// - id_rs2       in   5      ID source register 2
// - id_is_load   in   1      instruction in ID is a load
// - stall        out  1      hold PC/IF/ID and inject an EX bubble (combinational)
// - pending_cnt  out  CNT_W  number of valid entries (registered)
// - full         out  1      pending_cnt == DEPTH (registered)
// - empty        out  1      pending_cnt == 0 (registered)
// - err          out  1      sticky: overflow push or underflow pop seen
// BEHAVIOUR
// - Storage: circular FIFO of DEPTH entries {valid, rd[4:0]}, plus wr_ptr, rd_ptr and count.
// - Reset: all valid=0, pointers=0, pending_cnt=0, full=0, empty=1, err=0. Reset mid-operation discards all entries.
//   The pipeline is flushed by the same reset.
// - Push: on issue_valid && !stall. Write {1,issue_rd} at wr_ptr and advance wr_ptr, wrapping DEPTH-1 -> 0.
// - rd==0 is still pushed so that response matching stays aligned. Its entry never causes a stall.
// - Pop: on resp_valid && count!=0. Clear valid at rd_ptr and advance rd_ptr with wrap.
// - Simultaneous push and pop: both happen; count is unchanged. This is legal even when full.
// - Overflow: push attempted while full with no pop. Push is dropped; err<=1.
// - Underflow: resp_valid while empty. Ignored; err<=1.
// - err is cleared only by reset.
// - match(r): r!=0 AND some valid entry has rd==r.
//   - The head entry is excluded when resp_valid=1. The regfile is write-first, so that value is already available (bypass).
// - stall = match(id_rs1) | match(id_rs2) | (id_is_load & full & !resp_valid).
// - issue_valid arriving while stall=1 is a pipeline bug. It is never pushed.
// - Latency:
//   - A pushed tag affects stall from the next cycle.
//   - A popped tag stops affecting stall in the same cycle (bypass rule).
// - Duplicate rd values among pending entries are allowed. stall holds until the last matching entry pops.
// - pending_cnt, full and empty update on the clock edge after push/pop.
// STRUCTURE
// - Shared core package: REG_ADDR_W=5, REG_ZERO=5'd0. Reuse them; do not redefine.
// - One natural sub-module: tag_cam. It takes DEPTH valid bits, DEPTH tags, the head index, a head-exclude flag and a
//   query reg, and returns a hit. Instantiate it twice (rs1, rs2).
// - Pointer/count logic stays in the top module.
// TESTING
// 1 Reset -> stall=0, pending_cnt=0, empty=1, full=0, err=0.
// 2 Load x5 pushed. Next cycle id_rs1=5 -> stall=1 until resp_valid. On the resp_valid cycle stall=0. Afterwards
//   pending_cnt=0.
// 3 Push loads x1,x2,x3,x4. Then full=1, pending_cnt=4.
//   - id_is_load=1, no resp -> stall=1.
//   - Same with resp_valid=1 -> stall=0; the push is accepted and count stays 4.
// 4 Push x7 twice, then pop once. id_rs2=7 -> stall stays 1. Second pop -> stall=0.
// 5 Load to x0 pushed, id_rs1=0 -> stall=0. The later resp pops it and count returns to 0.
// 6 resp_valid while empty -> err=1, count stays 0. Then reset mid-stream with 3 entries -> all cleared, err=0.
// - Every scenario: pointer wrap after DEPTH+1 pushes/pops keeps in-order tag retirement.

Source files
------------

// File: rtl/load_scoreboard_pkg.sv
// Shared register-address definitions and tag helpers used by the load scoreboard.
package load_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // x0 is never a real dependency, so it can never produce a hit.
    function automatic logic tag_match(input reg_addr_t tag, input reg_addr_t query);
        return (query != REG_ZERO) && (tag == query);
    endfunction

endpackage

// File: rtl/tag_cam.sv
// Fully associative match of one source register against all pending load tags,
// optionally ignoring the head entry that is being written back this cycle.
module tag_cam
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0]      valid,
    input  reg_addr_t [DEPTH-1:0] tags,
    input  logic [IDX_W-1:0]      head,
    input  logic                  head_excl,
    input  reg_addr_t             query,
    output logic                  hit
);

    logic [DEPTH-1:0] entry_hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_hit[gi] = valid[gi]
                                 && !(head_excl && (head == IDX_W'(gi)))
                                 && tag_match(tags[gi], query);
        end
    endgenerate

    assign hit = |entry_hit;

endmodule

// File: rtl/load_scoreboard.sv
// In-order FIFO of destination registers for loads still in flight through the cache;
// drives the ID-stage load-use stall.
module load_scoreboard
    import load_scoreboard_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  reg_addr_t        issue_rd,
    input  logic             resp_valid,
    input  reg_addr_t        id_rs1,
    input  reg_addr_t        id_rs2,
    input  logic             id_is_load,
    output logic             stall,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]      valid_reg;
    reg_addr_t [DEPTH-1:0] tag_reg;
    logic [IDX_W-1:0]      wr_ptr_reg;
    logic [IDX_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  full_reg;
    logic                  empty_reg;
    logic                  err_reg;

    logic hit_rs1;
    logic hit_rs2;
    logic push_req;
    logic do_push;
    logic do_pop;
    logic overflow;
    logic underflow;

    tag_cam #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cam_rs1 (
        .valid     (valid_reg),
        .tags      (tag_reg),
        .head      (rd_ptr_reg),
        .head_excl (resp_valid),
        .query     (id_rs1),
        .hit       (hit_rs1)
    );

    tag_cam #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_cam_rs2 (
        .valid     (valid_reg),
        .tags      (tag_reg),
        .head      (rd_ptr_reg),
        .head_excl (resp_valid),
        .query     (id_rs2),
        .hit       (hit_rs2)
    );

    // A load in ID cannot issue into a full table unless a slot frees this cycle.
    assign stall = hit_rs1 | hit_rs2 | (id_is_load & full_reg & ~resp_valid);

    assign do_pop    = resp_valid & (count_reg != '0);
    assign underflow = resp_valid & (count_reg == '0);
    assign push_req  = issue_valid & ~stall;
    assign overflow  = push_req & full_reg & ~do_pop;
    assign do_push   = push_req & ~overflow;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= '0;
            tag_reg    <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            err_reg    <= 1'b0;
        end else begin
            // Pop is applied first so a same-slot push while full leaves the entry valid.
            if (do_pop) begin
                valid_reg[rd_ptr_reg] <= 1'b0;
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
            end
            if (do_push) begin
                valid_reg[wr_ptr_reg] <= 1'b1;
                tag_reg[wr_ptr_reg]   <= issue_rd;
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == CNT_W'(DEPTH));
            empty_reg <= (count_next == '0);
            if (overflow || underflow) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign pending_cnt = count_reg;
    assign full        = full_reg;
    assign empty       = empty_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed scoreboard bench for load_scoreboard: each stimulus cycle queues its expected
// outputs, and a negedge monitor pops and compares them.
module tb_load_scoreboard;

    logic       clk;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic       resp_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_is_load;
    logic       stall;
    logic [2:0] pending_cnt;
    logic       full;
    logic       empty;
    logic       err;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic       st;
        logic [2:0] cnt;
        logic       fl;
        logic       em;
        logic       er;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    load_scoreboard #(.DEPTH(4), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .resp_valid  (resp_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_is_load  (id_is_load),
        .stall       (stall),
        .pending_cnt (pending_cnt),
        .full        (full),
        .empty       (empty),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: drive just after the edge, queue what the outputs must be this cycle.
    task automatic step(input logic rst, input logic iv, input logic [4:0] ird, input logic rv,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic ld,
                        input logic est, input logic [2:0] ecnt, input logic efl,
                        input logic eem, input logic eer, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        issue_valid = iv;
        issue_rd    = ird;
        resp_valid  = rv;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_is_load  = ld;
        e.st = est; e.cnt = ecnt; e.fl = efl; e.em = eem; e.er = eer; e.name = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vec_count++;
            if (stall !== e.st || pending_cnt !== e.cnt || full !== e.fl ||
                empty !== e.em || err !== e.er) begin
                miss_count++;
                $display("FAIL %s: got stall=%b cnt=%0d full=%b empty=%b err=%b, need stall=%b cnt=%0d full=%b empty=%b err=%b",
                         e.name, stall, pending_cnt, full, empty, err,
                         e.st, e.cnt, e.fl, e.em, e.er);
            end else begin
                $display("ok   %s: stall=%b cnt=%0d full=%b empty=%b err=%b",
                         e.name, stall, pending_cnt, full, empty, err);
            end
        end
    end

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_rd = '0; resp_valid = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_is_load = 1'b0;
        repeat (2) @(posedge clk);

        //   rst iv rd  rv rs1 rs2 ld  | st cnt fl em er
        step(0, 0, 0,  0, 0,  0,  0,   0, 0, 0, 1, 0, "reset_state");

        // Single load x5, dependent in ID until writeback
        step(0, 1, 5,  0, 0,  0,  0,   0, 0, 0, 1, 0, "push_x5");
        step(0, 0, 0,  0, 5,  0,  0,   1, 1, 0, 0, 0, "use_x5_stall");
        step(0, 0, 0,  0, 5,  0,  0,   1, 1, 0, 0, 0, "use_x5_hold");
        step(0, 0, 0,  1, 5,  0,  0,   0, 1, 0, 0, 0, "x5_resp_bypass");
        step(0, 0, 0,  0, 5,  0,  0,   0, 0, 0, 1, 0, "x5_retired");

        // Fill, full-table load stall, push+pop while full, drain in order
        step(0, 1, 1,  0, 0,  0,  0,   0, 0, 0, 1, 0, "push_x1");
        step(0, 1, 2,  0, 0,  0,  0,   0, 1, 0, 0, 0, "push_x2");
        step(0, 1, 3,  0, 0,  0,  0,   0, 2, 0, 0, 0, "push_x3");
        step(0, 1, 4,  0, 0,  0,  0,   0, 3, 0, 0, 0, "push_x4");
        step(0, 0, 0,  0, 0,  0,  1,   1, 4, 1, 0, 0, "full_load_stall");
        step(0, 1, 6,  1, 0,  0,  1,   0, 4, 1, 0, 0, "full_push_pop");
        step(0, 0, 0,  0, 1,  0,  0,   0, 4, 1, 0, 0, "x1_gone");
        step(0, 0, 0,  0, 0,  6,  0,   1, 4, 1, 0, 0, "x6_pending");
        step(0, 0, 0,  1, 2,  0,  0,   0, 4, 1, 0, 0, "pop_x2");
        step(0, 0, 0,  1, 3,  2,  0,   0, 3, 0, 0, 0, "pop_x3");
        step(0, 0, 0,  1, 4,  6,  0,   1, 2, 0, 0, 0, "pop_x4_x6_wait");
        step(0, 0, 0,  1, 6,  0,  0,   0, 1, 0, 0, 0, "pop_x6");
        step(0, 0, 0,  0, 6,  4,  0,   0, 0, 0, 1, 0, "drained");

        // Duplicate x7; blocked issue while stalled must not be pushed
        step(0, 1, 7,  0, 0,  0,  0,   0, 0, 0, 1, 0, "push_x7_a");
        step(0, 1, 7,  0, 0,  0,  0,   0, 1, 0, 0, 0, "push_x7_b");
        step(0, 0, 0,  1, 0,  7,  0,   1, 2, 0, 0, 0, "pop_x7_a_dup_stall");
        step(0, 1, 12, 0, 0,  7,  0,   1, 1, 0, 0, 0, "stalled_issue");
        step(0, 0, 0,  1, 0,  7,  0,   0, 1, 0, 0, 0, "pop_x7_b");
        step(0, 0, 0,  0, 0,  7,  0,   0, 0, 0, 1, 0, "x7_clear");

        // Load to x0 never stalls but still occupies a slot
        step(0, 1, 0,  0, 0,  0,  0,   0, 0, 0, 1, 0, "push_x0");
        step(0, 0, 0,  0, 0,  0,  0,   0, 1, 0, 0, 0, "x0_no_stall");
        step(0, 0, 0,  1, 0,  0,  0,   0, 1, 0, 0, 0, "pop_x0");
        step(0, 0, 0,  0, 0,  0,  0,   0, 0, 0, 1, 0, "x0_retired");

        // Underflow, then reset with entries in flight
        step(0, 0, 0,  1, 0,  0,  0,   0, 0, 0, 1, 0, "underflow_resp");
        step(0, 1, 10, 0, 0,  0,  0,   0, 0, 0, 1, 1, "err_set_push_x10");
        step(0, 1, 11, 0, 0,  0,  0,   0, 1, 0, 0, 1, "push_x11");
        step(0, 1, 12, 0, 0,  0,  0,   0, 2, 0, 0, 1, "push_x12");
        step(0, 0, 0,  0, 11, 0,  0,   1, 3, 0, 0, 1, "x11_pending");
        step(1, 0, 0,  0, 11, 0,  0,   1, 3, 0, 0, 1, "reset_asserted");
        step(0, 0, 0,  0, 11, 0,  0,   0, 0, 0, 1, 0, "reset_cleared");

        // Overflow drops the push; in-order drain across the wrap
        step(0, 1, 13, 0, 0,  0,  0,   0, 0, 0, 1, 0, "push_x13");
        step(0, 1, 14, 0, 0,  0,  0,   0, 1, 0, 0, 0, "push_x14");
        step(0, 1, 15, 0, 0,  0,  0,   0, 2, 0, 0, 0, "push_x15");
        step(0, 1, 16, 0, 0,  0,  0,   0, 3, 0, 0, 0, "push_x16");
        step(0, 1, 17, 0, 0,  0,  0,   0, 4, 1, 0, 0, "overflow_x17");
        step(0, 0, 0,  0, 17, 0,  0,   0, 4, 1, 0, 1, "x17_dropped");
        step(0, 0, 0,  1, 13, 0,  0,   0, 4, 1, 0, 1, "pop_x13");
        step(0, 0, 0,  1, 14, 16, 0,   1, 3, 0, 0, 1, "pop_x14_x16_wait");
        step(0, 0, 0,  1, 15, 0,  0,   0, 2, 0, 0, 1, "pop_x15");
        step(0, 0, 0,  1, 16, 0,  0,   0, 1, 0, 0, 1, "pop_x16");
        step(0, 0, 0,  0, 16, 0,  0,   0, 0, 0, 1, 1, "final_empty");

        @(posedge clk);
        #1;
        resp_valid = 1'b0; issue_valid = 1'b0;
        repeat (2) @(posedge clk);
        vec_count++;
        if (exp_q.size() != 0) begin
            miss_count++;
            $display("FAIL scoreboard_drain: %0d expectations left, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
